// File: rtl/z3_to_z1_serializer.sv
// Restores a 3-phase parallel frame stream to one rounded, saturated sample per clock.
// Optional saturation event counter (sat_cnt port) is built with Z3TOZ1_SAT_CNT_EN.
module z3_to_z1_serializer #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  In [0:2],
  input  logic                    in_valid,
  input  logic                    clr_err,
  output logic signed [OUT_W-1:0] Out,
  output logic                    out_valid,
  output logic                    err_overrun,
  output logic                    err_underrun
`ifdef Z3TOZ1_SAT_CNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int SH     = IN_W - OUT_W;
  localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [IN_W:0] RND  = (SH > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_SH) : '0;
  localparam logic signed [IN_W:0] QMAX = {{(SH+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] QMIN = {{(SH+2){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Sum carried in IN_W+1 bits so the rounding offset can never wrap.
  function automatic logic signed [IN_W:0] shifted(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] sum;
    sum = $signed({x[IN_W-1], x}) + RND;
    return sum >>> SH;
  endfunction

  function automatic logic signed [OUT_W-1:0] quant(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] shr;
    shr = shifted(x);
    if (shr > QMAX)
      return QMAX[OUT_W-1:0];
    else if (shr < QMIN)
      return QMIN[OUT_W-1:0];
    else
      return shr[OUT_W-1:0];
  endfunction

  logic signed [OUT_W-1:0] w_q [0:2];
  logic signed [OUT_W-1:0] r_out;
  logic signed [OUT_W-1:0] r_hold1;
  logic signed [OUT_W-1:0] r_hold0;
  logic                    r_valid;
  logic                    r_ovr;
  logic                    r_udr;
  logic [1:0]              r_phase;
  logic [0:0]              r_state;

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      w_q[i] = quant(In[i]);
    end
  end

  // A strobe always loads, whatever the phase; mid-frame it also flags overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= '0;
      r_hold1 <= '0;
      r_hold0 <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_udr   <= 1'b0;
      r_phase <= 2'd0;
      r_state <= S_IDLE;
    end else begin
      if (clr_err) begin
        r_ovr <= 1'b0;
        r_udr <= 1'b0;
      end
      if (in_valid) begin
        r_out   <= w_q[2];
        r_hold1 <= w_q[1];
        r_hold0 <= w_q[0];
        r_valid <= 1'b1;
        r_phase <= 2'd1;
        r_state <= S_RUN;
        if (r_state == S_RUN && r_phase != 2'd0)
          r_ovr <= 1'b1;
      end else if (r_state == S_RUN) begin
        case (r_phase)
          2'd1: begin
            r_out   <= r_hold1;
            r_phase <= 2'd2;
          end
          2'd2: begin
            r_out   <= r_hold0;
            r_phase <= 2'd0;
          end
          default: begin
            // Phase 0 in RUN is only reachable after a completed frame.
            r_out   <= '0;
            r_valid <= 1'b0;
            r_phase <= 2'd0;
            r_state <= S_IDLE;
            r_udr   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Out          = r_out;
  assign out_valid    = r_valid;
  assign err_overrun  = r_ovr;
  assign err_underrun = r_udr;

`ifdef Z3TOZ1_SAT_CNT_EN
  logic [1:0]  w_nclip;
  logic [15:0] w_sat_base;
  logic [16:0] w_sat_sum;
  logic [15:0] r_sat_cnt;

  function automatic logic clipped(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] shr;
    shr = shifted(x);
    return (shr > QMAX) || (shr < QMIN);
  endfunction

  always_comb begin
    w_nclip = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_nclip = w_nclip + {1'b0, clipped(In[i])};
    end
    w_sat_base = clr_err ? '0 : r_sat_cnt;
    w_sat_sum  = {1'b0, w_sat_base} + (in_valid ? {15'd0, w_nclip} : 17'd0);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_sat_cnt <= '0;
    else
      r_sat_cnt <= w_sat_sum[16] ? '1 : w_sat_sum[15:0];
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
